// File: rtl/sr_frame_sync.sv
// sr_frame_sync: hunts for a 4-bit sync pattern in a serial shift-register window, then
// captures NIBBLES consecutive non-overlapping 4-bit windows and presents them as one
// parallel frame word. Keeps a saturating count of completed frames.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   en         - one new serial bit has entered `state` this cycle
//   state      - shift-register window, state[0] newest bit
//   cnt_clr    - synchronous clear of frame_cnt (wins over increment)
//   data_out   - last completed frame, first captured nibble in the MS bits
//   data_valid - one-cycle pulse when data_out updates
//   sync_hit   - one-cycle pulse when the sync pattern is accepted
//   busy       - high while collecting a frame
//   frame_cnt  - saturating count of completed frames
module sr_frame_sync #(
    parameter logic [3:0]  SYNC_PAT = 4'b1011,
    parameter int unsigned NIBBLES  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [3:0]             state,
    input  logic                   cnt_clr,
    output logic [4*NIBBLES-1:0]   data_out,
    output logic                   data_valid,
    output logic                   sync_hit,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_cnt
);

    localparam int unsigned FrameW  = 4 * NIBBLES;
    localparam logic [2:0]  LastIdx = 3'(NIBBLES - 1);

    typedef enum logic {
        StHunt    = 1'b0,
        StCollect = 1'b1
    } fsm_e;

    fsm_e              r_fsm,        w_fsm_nxt;
    logic [1:0]        r_bit_cnt,    w_bit_cnt_nxt;
    logic [2:0]        r_nib_idx,    w_nib_idx_nxt;
    logic [FrameW-1:0] r_buf,        w_buf_nxt;
    logic [FrameW-1:0] r_data_out,   w_data_out_nxt;
    logic              r_data_valid, w_data_valid_nxt;
    logic              r_sync_hit,   w_sync_hit_nxt;
    logic [CNT_W-1:0]  r_frame_cnt,  w_frame_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm        <= StHunt;
            r_bit_cnt    <= '0;
            r_nib_idx    <= '0;
            r_buf        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sync_hit   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_nib_idx    <= w_nib_idx_nxt;
            r_buf        <= w_buf_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_sync_hit   <= w_sync_hit_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_nib_idx_nxt    = r_nib_idx;
        w_buf_nxt        = r_buf;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = 1'b0;
        w_sync_hit_nxt   = 1'b0;

        if (en) begin
            unique case (r_fsm)
                StHunt: begin
                    if (state == SYNC_PAT) begin
                        w_fsm_nxt      = StCollect;
                        w_bit_cnt_nxt  = '0;
                        w_nib_idx_nxt  = '0;
                        w_sync_hit_nxt = 1'b1;
                    end
                end
                StCollect: begin
                    if (r_bit_cnt != 2'd3) begin
                        w_bit_cnt_nxt = r_bit_cnt + 2'd1;
                    end else begin
                        // Four fresh bits since the last window: window is disjoint, capture it.
                        for (int unsigned k = 0; k < NIBBLES; k++) begin
                            if (r_nib_idx == 3'(k)) begin
                                w_buf_nxt[FrameW-4-4*k +: 4] = state;
                            end
                        end
                        w_bit_cnt_nxt = '0;
                        if (r_nib_idx == LastIdx) begin
                            // Frame complete; the returning edge does not test for sync.
                            w_data_out_nxt   = w_buf_nxt;
                            w_data_valid_nxt = 1'b1;
                            w_nib_idx_nxt    = '0;
                            w_fsm_nxt        = StHunt;
                        end else begin
                            w_nib_idx_nxt = r_nib_idx + 3'd1;
                        end
                    end
                end
                default: w_fsm_nxt = StHunt;
            endcase
        end
    end

    // Counter moves together with data_out so both are visible in the data_valid cycle.
    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (cnt_clr) begin
            w_frame_cnt_nxt = '0;
        end else if (w_data_valid_nxt && (r_frame_cnt != {CNT_W{1'b1}})) begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sync_hit   = r_sync_hit;
    assign busy       = (r_fsm == StCollect);
    assign frame_cnt  = r_frame_cnt;

endmodule
